// File: rtl/rr_mux4.sv
// rr_mux4: 4-to-1 valid/ready stream merge, round-robin grant,
// registered output tagged with source index, optional packet lock.
module rr_mux4 #(
  parameter int WIDTH    = 8,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] last_grant_q;
  logic [1:0] lock_ch_q;
  logic [1:0] lock_ch_d;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       gnt_vld;
  logic       load;
  logic       accept;

  assign load = ~out_valid | out_ready;

  // Offsets scanned high to low so the nearest requester after
  // last_grant overwrites the rest.
  always_comb begin
    gnt     = last_grant_q;
    gnt_vld = 1'b0;
    idx     = '0;
    unique case (1'b1)
      (state_q == LOCK): begin
        gnt     = lock_ch_q;
        gnt_vld = in_valid[lock_ch_q];
      end
      default: begin
        for (int i = 4; i >= 1; i--) begin
          idx = last_grant_q + 2'(i);
          if (in_valid[idx]) begin
            gnt     = idx;
            gnt_vld = 1'b1;
          end
        end
      end
    endcase
  end

  assign accept = rst_n & load & gnt_vld;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    unique case (state_q)
      ARB: begin
        if (PKT_LOCK && accept && !in_last[gnt]) begin
          state_d   = LOCK;
          lock_ch_d = gnt;
        end
      end
      LOCK: begin
        if (accept && in_last[gnt]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      lock_ch_q    <= '0;
      last_grant_q <= 2'd3;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      if (accept) last_grant_q <= gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt*WIDTH +: WIDTH];
      out_last  <= in_last[gnt];
      out_sel   <= gnt;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule
